seven_seg_mux_driver: RTL

Output-side counterpart of the switch debouncer: where the debouncer conditions a noisy front-panel input, this block drives the two-digit, common-anode seven-segment display on the front panel. It latches an 8-bit value and shows it as two hex digits by time-multiplexing the shared segment lines. A blanking interval at every digit switch prevents ghosting, and new values are applied only at frame boundaries so the display never tears. It sits between the counter logic and the board pins.

---
 rtl/seven_seg_mux_driver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver
//
// Drives a two-digit, common-anode seven-segment display from an 8-bit value.
// The value is captured into a shadow register on i_Load and promoted to the
// display register only at a frame boundary (SHOW_1 -> BLANK_0), so a frame
// never shows a mix of old and new digits. Each digit slot starts with a
// blanking interval so the shared segment lines settle with both anodes off.
//
// Parameters:
//   c_REFRESH_LIMIT  cycles per digit slot (2..65535)
//   c_BLANK_CYCLES   blanked cycles at the start of each slot (1..c_REFRESH_LIMIT-1)
//
// Ports:
//   i_Clk       system clock
//   i_Rst_n     asynchronous, active-low reset
//   i_Value     value to display; [3:0] ones digit, [7:4] tens digit
//   i_Load      single-cycle strobe that samples i_Value
//   o_Segment   segment drive, active-low; bit0 = a ... bit6 = g
//   o_Digit_En  anode enables, active-low; bit0 = ones, bit1 = tens
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN  when defined, a zero tens digit is left dark
//                               (slot timing is unchanged).

module seven_seg_mux_driver #(
  parameter int unsigned c_REFRESH_LIMIT = 25000,
  parameter int unsigned c_BLANK_CYCLES  = 250
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [7:0] i_Value,
  input  logic       i_Load,
  output logic [6:0] o_Segment,
  output logic [1:0] o_Digit_En
);

  // States are numbered in visiting order so the next state is simply +1
  // (SHOW_1 wraps to BLANK_0). Bit 0 clear marks a blanking state.
  localparam logic [1:0] BLANK_0 = 2'd0;
  localparam logic [1:0] SHOW_0  = 2'd1;
  localparam logic [1:0] BLANK_1 = 2'd2;
  localparam logic [1:0] SHOW_1  = 2'd3;

  localparam logic [15:0] c_BLANK_LAST = 16'(c_BLANK_CYCLES - 1);
  localparam logic [15:0] c_SHOW_LAST  = 16'(c_REFRESH_LIMIT - c_BLANK_CYCLES - 1);

  localparam logic [6:0] c_SEG_OFF = 7'h7F;
  localparam logic [1:0] c_EN_OFF  = 2'b11;

  logic [1:0]  r_State;
  logic [15:0] r_Count;
  logic [7:0]  r_Shadow;
  logic [7:0]  r_Disp;
  logic        w_Slot_End;
  logic [6:0]  w_Segment;
  logic [1:0]  w_Digit_En;

  // Hex to segments, active-high g..a; inverted at the output register.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // A slot ends on the last counted cycle of the current state.
  assign w_Slot_End = r_State[0] ? (r_Count == c_SHOW_LAST)
                                 : (r_Count == c_BLANK_LAST);

  // Slot sequencer, shadow capture and frame-boundary promotion.
  // NOTE: every register here, including the small shadow/display data
  // registers, is reset so the first frame after reset reliably shows "00".
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State  <= BLANK_0;
      r_Count  <= '0;
      r_Shadow <= '0;
      r_Disp   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, which is what makes a load on the boundary cycle
      // land in the shadow while r_Disp takes the old shadow.
      if (i_Load) begin
        r_Shadow <= i_Value;
      end
      if (w_Slot_End) begin
        r_State <= r_State + 2'd1;
        r_Count <= '0;
        if (r_State == SHOW_1) begin
          r_Disp <= r_Shadow;
        end
      end else begin
        r_Count <= r_Count + 16'd1;
      end
    end
  end

  // Output decode for the current state; registered below.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch forms.
    w_Segment  = c_SEG_OFF;
    w_Digit_En = c_EN_OFF;
    case (r_State)
      SHOW_0: begin
        w_Digit_En = 2'b10;
        w_Segment  = ~hex_to_seg(r_Disp[3:0]);
      end
      SHOW_1: begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (r_Disp[7:4] != 4'h0) begin
          w_Digit_En = 2'b01;
          w_Segment  = ~hex_to_seg(r_Disp[7:4]);
        end
`else
        w_Digit_En = 2'b01;
        w_Segment  = ~hex_to_seg(r_Disp[7:4]);
`endif
      end
      default: begin
        w_Segment  = c_SEG_OFF;
        w_Digit_En = c_EN_OFF;
      end
    endcase
  end

  // Registered pin drivers; reset forces the display dark without a clock.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Segment  <= c_SEG_OFF;
      o_Digit_En <= c_EN_OFF;
    end else begin
      o_Segment  <= w_Segment;
      o_Digit_En <= w_Digit_En;
    end
  end

endmodule
